// File: rtl/mips_lite_core.sv
// Three-stage (IF / EX / WB) MIPS-subset core with a 16-bit address space.
// EX does decode, operand read, ALU, branch resolve and the data-memory access.
module mips_lite_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstrMem,
  output logic [15:0] InstrAddr,
  input  logic [31:0] MemData,
  output logic [31:0] WriteData,
  output logic [15:0] MemAddr,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [4:0]  RegAddr,
  output logic [31:0] RegData
);

  logic [15:0] pc, pc_ex, npc, tgt, seq;
  logic [31:0] ir;
  logic [1:0]  vld_pipe;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rf [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs_a, rt_a, rd_a, shamt, dst;
  logic [15:0] imm;
  logic [31:0] simm, zimm, rs_v, rt_v, res;
  logic        we, mrd, mwr, take;

  assign op    = ir[31:26];
  assign rs_a  = ir[25:21];
  assign rt_a  = ir[20:16];
  assign rd_a  = ir[15:11];
  assign shamt = ir[10:6];
  assign funct = ir[5:0];
  assign imm   = ir[15:0];
  assign simm  = {{16{imm[15]}}, imm};
  assign zimm  = {16'h0000, imm};
  assign seq   = pc_ex + 16'd4;

  // Reads bypass the value retiring from WB this cycle, so a result is usable next instruction.
  assign rs_v    = (rs_a == 5'd0) ? 32'd0 : (wb_we && wb_rd == rs_a) ? wb_data : rf[rs_a];
  assign rt_v    = (rt_a == 5'd0) ? 32'd0 : (wb_we && wb_rd == rt_a) ? wb_data : rf[rt_a];
  assign RegData = (RegAddr == 5'd0) ? 32'd0 :
                   (wb_we && wb_rd == RegAddr) ? wb_data : rf[RegAddr];

  always_comb begin
    res  = '0;
    we   = 1'b0;
    dst  = rd_a;
    mrd  = 1'b0;
    mwr  = 1'b0;
    take = 1'b0;
    tgt  = seq + {imm[13:0], 2'b00};
    case (op)
      6'h00: begin
        we = 1'b1;
        case (funct)
          6'h20, 6'h21: res = rs_v + rt_v;
          6'h22, 6'h23: res = rs_v - rt_v;
          6'h24: res = rs_v & rt_v;
          6'h25: res = rs_v | rt_v;
          6'h26: res = rs_v ^ rt_v;
          6'h27: res = ~(rs_v | rt_v);
          6'h2A: res = {31'd0, $signed(rs_v) < $signed(rt_v)};
          6'h2B: res = {31'd0, rs_v < rt_v};
          6'h00: res = rt_v << shamt;
          6'h02: res = rt_v >> shamt;
          6'h03: res = $signed(rt_v) >>> shamt;
          6'h04: res = rt_v << rs_v[4:0];
          6'h06: res = rt_v >> rs_v[4:0];
          6'h07: res = $signed(rt_v) >>> rs_v[4:0];
          6'h08: begin we = 1'b0; take = 1'b1; tgt = rs_v[15:0]; end
          default: we = 1'b0;
        endcase
      end
      6'h08, 6'h09: begin dst = rt_a; we = 1'b1; res = rs_v + simm; end
      6'h0A: begin dst = rt_a; we = 1'b1; res = {31'd0, $signed(rs_v) < $signed(simm)}; end
      6'h0B: begin dst = rt_a; we = 1'b1; res = {31'd0, rs_v < simm}; end
      6'h0C: begin dst = rt_a; we = 1'b1; res = rs_v & zimm; end
      6'h0D: begin dst = rt_a; we = 1'b1; res = rs_v | zimm; end
      6'h0E: begin dst = rt_a; we = 1'b1; res = rs_v ^ zimm; end
      6'h0F: begin dst = rt_a; we = 1'b1; res = {imm, 16'h0000}; end
      6'h23: begin dst = rt_a; we = 1'b1; mrd = 1'b1; res = rs_v + simm; end
      6'h2B: begin mwr = 1'b1; res = rs_v + simm; end
      6'h04: take = (rs_v == rt_v);
      6'h05: take = (rs_v != rt_v);
      6'h02: begin take = 1'b1; tgt = {seq[15:12], ir[9:0], 2'b00}; end
      6'h03: begin
        take = 1'b1;
        tgt  = {seq[15:12], ir[9:0], 2'b00};
        we   = 1'b1;
        dst  = 5'd31;
        res  = {16'h0000, pc_ex + 16'd8};
      end
      default: ;
    endcase
    we   = we && vld_pipe[0] && (dst != 5'd0);
    mrd  = mrd && vld_pipe[0];
    mwr  = mwr && vld_pipe[0];
    take = take && vld_pipe[0];
  end

  assign npc       = take ? tgt : pc + 16'd4;
  assign InstrAddr = pc;
  assign MemAddr   = res[15:0];
  assign WriteData = rt_v;
  assign MemWrite  = mwr;
  assign MemRead   = mrd;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pc       <= RESET_PC;
      pc_ex    <= '0;
      ir       <= '0;
      vld_pipe <= '0;
      wb_we    <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      pc       <= npc;
      pc_ex    <= pc;
      ir       <= InstrMem;
      vld_pipe <= {vld_pipe[0], 1'b1};
      wb_we    <= we;
      wb_rd    <= dst;
      wb_data  <= mrd ? MemData : res;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (wb_we && vld_pipe[1]) begin
      rf[wb_rd] <= wb_data;
    end
  end

endmodule

// File: tb/tb_mips_lite_core.sv
// Directed-program bench for mips_lite_core; imem/dmem are modelled here.
`timescale 1ns/1ps
module tb_mips_lite_core;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] InstrMem, MemData, WriteData, RegData;
  logic [15:0] InstrAddr, MemAddr;
  logic        MemWrite, MemRead;
  logic [4:0]  RegAddr = '0;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int checks = 0;
  int errors = 0;

  mips_lite_core #(.RESET_PC(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .InstrMem(InstrMem), .InstrAddr(InstrAddr),
    .MemData(MemData), .WriteData(WriteData), .MemAddr(MemAddr),
    .MemWrite(MemWrite), .MemRead(MemRead), .RegAddr(RegAddr), .RegData(RegData)
  );

  always #50 Clock = ~Clock;

  assign InstrMem = imem[InstrAddr[9:2]];
  assign MemData  = dmem[MemAddr[9:2]];
  always @(posedge Clock) if (MemWrite) dmem[MemAddr[9:2]] <= WriteData;

  function automatic logic [31:0] r_op(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction
  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] j_op(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic reg_is(input string tag, input logic [4:0] a, input logic [31:0] exp);
    RegAddr = a;
    #1;
    check(tag, RegData, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Leaves Reset high, 1ns after an edge, with both memories cleared.
  task automatic hold_reset();
    Reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'd0;
      dmem[i] = 32'd0;
    end
    step(2);
  endtask

  initial begin
    // Reset state and sequential fetch
    hold_reset();
    check("rst_memwrite", MemWrite, 0);
    check("rst_memread", MemRead, 0);
    check("rst_pc", InstrAddr, 16'h0000);
    check("rst_memaddr", MemAddr, 0);
    check("rst_wdata", WriteData, 0);
    Reset = 1'b0;
    check("pc_c0", InstrAddr, 16'h0000);
    step(1); check("pc_c1", InstrAddr, 16'h0004);
    step(1); check("pc_c2", InstrAddr, 16'h0008);
    step(1); check("pc_c3", InstrAddr, 16'h000C);
    for (int i = 0; i < 32; i++) reg_is("rst_reg", 5'(i), 32'd0);

    // Immediate / ALU
    hold_reset();
    imem[0] = i_op(6'h08, 0, 1, 16'd5);
    imem[1] = i_op(6'h08, 0, 2, 16'hFFFD);
    imem[2] = r_op(1, 2, 3, 0, 6'h20);
    imem[3] = r_op(2, 1, 4, 0, 6'h22);
    imem[4] = r_op(2, 1, 5, 0, 6'h2A);
    imem[5] = r_op(2, 1, 6, 0, 6'h2B);
    Reset = 1'b0;
    step(2); reg_is("addi_lat2", 1, 32'd5);
    step(2); reg_is("add_lat2", 3, 32'd2);
    step(6);
    reg_is("alu_r2", 2, 32'hFFFFFFFD);
    reg_is("alu_add", 3, 32'd2);
    reg_is("alu_sub", 4, 32'hFFFFFFF8);
    reg_is("alu_slt", 5, 32'd1);
    reg_is("alu_sltu", 6, 32'd0);

    // Logic and shift
    hold_reset();
    imem[0] = i_op(6'h0F, 0, 1, 16'h1234);
    imem[1] = i_op(6'h0D, 1, 1, 16'h5678);
    imem[2] = r_op(0, 1, 2, 4, 6'h03);
    imem[3] = r_op(0, 1, 3, 8, 6'h00);
    imem[4] = r_op(0, 0, 4, 0, 6'h27);
    imem[5] = i_op(6'h0B, 1, 6, 16'hFFFF);
    imem[6] = i_op(6'h0E, 1, 7, 16'hFFFF);
    imem[7] = r_op(1, 1, 0, 0, 6'h20);
    imem[8] = r_op(0, 4, 8, 4, 6'h03);
    imem[9] = r_op(6, 4, 9, 0, 6'h06);
    Reset = 1'b0;
    step(14);
    reg_is("lui_ori", 1, 32'h12345678);
    reg_is("sra", 2, 32'h01234567);
    reg_is("sll", 3, 32'h34567800);
    reg_is("nor", 4, 32'hFFFFFFFF);
    reg_is("sltiu", 6, 32'd1);
    reg_is("xori_zext", 7, 32'h1234A987);
    reg_is("zero_reg", 0, 32'd0);
    reg_is("sra_neg", 8, 32'hFFFFFFFF);
    reg_is("srlv", 9, 32'h7FFFFFFF);

    // Memory
    hold_reset();
    imem[0] = i_op(6'h08, 0, 1, 16'h0040);
    imem[1] = i_op(6'h2B, 1, 1, 16'd4);
    imem[2] = i_op(6'h23, 1, 2, 16'd4);
    imem[3] = r_op(2, 2, 3, 0, 6'h20);
    Reset = 1'b0;
    step(2);
    check("sw_memwrite", MemWrite, 1);
    check("sw_memaddr", MemAddr, 16'h0044);
    check("sw_wdata", WriteData, 32'h40);
    check("sw_memread", MemRead, 0);
    step(1);
    check("lw_memread", MemRead, 1);
    check("lw_memwrite", MemWrite, 0);
    check("lw_memaddr", MemAddr, 16'h0044);
    step(6);
    check("dmem_word", dmem[8'h11], 32'h40);
    reg_is("lw_reg", 2, 32'h40);
    reg_is("lw_fwd_add", 3, 32'h80);

    // Branch taken with delay slot
    hold_reset();
    imem[0] = i_op(6'h04, 0, 0, 16'd2);
    imem[1] = i_op(6'h08, 0, 1, 16'd7);
    imem[2] = i_op(6'h08, 0, 2, 16'd9);
    imem[3] = i_op(6'h08, 0, 3, 16'd11);
    Reset = 1'b0;
    check("beq_pc0", InstrAddr, 16'h0000);
    step(1); check("beq_pc1", InstrAddr, 16'h0004);
    step(1); check("beq_pc2", InstrAddr, 16'h000C);
    step(6);
    reg_is("beq_slot", 1, 32'd7);
    reg_is("beq_skip", 2, 32'd0);
    reg_is("beq_tgt", 3, 32'd11);

    // BNE with equal operands falls through
    hold_reset();
    imem[0] = i_op(6'h05, 0, 0, 16'd2);
    imem[1] = i_op(6'h08, 0, 1, 16'd7);
    imem[2] = i_op(6'h08, 0, 2, 16'd9);
    Reset = 1'b0;
    step(1); check("bne_pc1", InstrAddr, 16'h0004);
    step(1); check("bne_pc2", InstrAddr, 16'h0008);
    step(6);
    reg_is("bne_fall", 2, 32'd9);

    // J
    hold_reset();
    imem[2]  = j_op(6'h02, 26'h10);
    imem[3]  = i_op(6'h08, 0, 1, 16'd1);
    imem[16] = i_op(6'h08, 0, 2, 16'd2);
    Reset = 1'b0;
    step(2); check("j_pc8", InstrAddr, 16'h0008);
    step(1); check("j_pc12", InstrAddr, 16'h000C);
    step(1); check("j_pc40", InstrAddr, 16'h0040);
    step(6);
    reg_is("j_slot", 1, 32'd1);
    reg_is("j_tgt", 2, 32'd2);
    reg_is("j_no_link", 31, 32'd0);

    // JAL / JR
    hold_reset();
    imem[2]  = j_op(6'h03, 26'h10);
    imem[3]  = i_op(6'h08, 0, 1, 16'd1);
    imem[4]  = i_op(6'h08, 0, 4, 16'd4);
    imem[5]  = i_op(6'h08, 0, 0, 16'd5);
    imem[16] = i_op(6'h08, 0, 2, 16'd2);
    imem[17] = r_op(31, 0, 0, 0, 6'h08);
    imem[18] = i_op(6'h08, 0, 3, 16'd3);
    imem[19] = i_op(6'h08, 0, 5, 16'd5);
    Reset = 1'b0;
    step(3); check("jal_pc12", InstrAddr, 16'h000C);
    step(1); check("jal_pc40", InstrAddr, 16'h0040);
    reg_is("jal_link", 31, 32'd16);
    step(2); check("jr_pc48", InstrAddr, 16'h0048);
    step(1); check("jr_pc16", InstrAddr, 16'h0010);
    step(6);
    reg_is("jal_slot", 1, 32'd1);
    reg_is("jal_tgt", 2, 32'd2);
    reg_is("jr_slot", 3, 32'd3);
    reg_is("jr_ret", 4, 32'd4);
    reg_is("jr_skip", 5, 32'd0);
    reg_is("zero_after_write", 0, 32'd0);

    // Reset asserted mid-program
    hold_reset();
    imem[0] = i_op(6'h08, 0, 1, 16'd5);
    imem[1] = i_op(6'h08, 0, 2, 16'hFFFD);
    imem[2] = r_op(1, 2, 3, 0, 6'h20);
    Reset = 1'b0;
    step(3);
    reg_is("mid_pre", 1, 32'd5);
    Reset = 1'b1;
    #1;
    check("mid_pc", InstrAddr, 16'h0000);
    check("mid_memread", MemRead, 0);
    reg_is("mid_reg_clr", 1, 32'd0);
    step(1);
    Reset = 1'b0;
    check("mid_restart0", InstrAddr, 16'h0000);
    step(1); check("mid_restart4", InstrAddr, 16'h0004);
    step(8);
    reg_is("mid_rerun", 3, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
